// File: rtl/riscv_pkg.sv
`default_nettype none
// =============================================================================
// Package  : riscv_pkg
// Brief    : Shared architectural constants for the integer register file.
// Revision : 1.0 - initial release
// =============================================================================
package riscv_pkg;

  localparam int RV_XLEN   = 32;
  localparam int RV_NREGS  = 32;
  localparam int RV_REG_AW = $clog2(RV_NREGS);

  localparam logic [RV_REG_AW-1:0] RV_X0 = '0;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// =============================================================================
// Module   : reg_scoreboard
// Brief    : One pending bit per architectural register, set on issue and
//            cleared on write-back, with two combinational lookup ports.
// Revision : 1.0 - initial release
// =============================================================================
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS = RV_NREGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en_i,
  input  logic [$clog2(NREGS)-1:0] set_idx_i,
  input  logic                     clr_en_i,
  input  logic [$clog2(NREGS)-1:0] clr_idx_i,
  input  logic [$clog2(NREGS)-1:0] look1_idx_i,
  output logic                     look1_pend_o,
  input  logic [$clog2(NREGS)-1:0] look2_idx_i,
  output logic                     look2_pend_o
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Set is applied after clear so a newer producer to the same index wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) begin
      pending_d[clr_idx_i] = 1'b0;
    end
    if (set_en_i && (set_idx_i != AW'(RV_X0))) begin
      pending_d[set_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign look1_pend_o = pending_q[look1_idx_i];
  assign look2_pend_o = pending_q[look2_idx_i];

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/regfile_read.sv
`default_nettype none
// =============================================================================
// Module   : regfile_read
// Brief    : Integer register file with registered dual read, write-back port
//            and pending-bit interlock. Define REGFILE_BYPASS_EN to forward
//            same-cycle write-back data into the read and suppress its stall.
// Revision : 1.0 - initial release
// =============================================================================
module regfile_read
  import riscv_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int NREGS = RV_NREGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     issue_en,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  input  logic                     rd_req,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  output logic                     rd_vld,
  output logic                     stall
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0] rs1_d, rs2_d;
  logic            rd_vld_q;
  logic            pend1, pend2;
  logic            fwd1, fwd2;
  logic            rd_accept;
  logic            rs1_nz, rs2_nz;

  assign rs1_nz = (rs1_addr != AW'(RV_X0));
  assign rs2_nz = (rs2_addr != AW'(RV_X0));

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .set_en_i     (issue_en),
    .set_idx_i    (issue_rd),
    .clr_en_i     (wb_en),
    .clr_idx_i    (wb_rd),
    .look1_idx_i  (rs1_addr),
    .look1_pend_o (pend1),
    .look2_idx_i  (rs2_addr),
    .look2_pend_o (pend2)
  );

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wb_en && (wb_rd == rs1_addr) && rs1_nz;
  assign fwd2 = wb_en && (wb_rd == rs2_addr) && rs2_nz;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // A forwarded operand is resolved this cycle, so its pending bit is ignored.
  assign stall     = rd_req && ((pend1 && rs1_nz && !fwd1) || (pend2 && rs2_nz && !fwd2));
  assign rd_accept = rd_req && !stall;

  always_comb begin
    rs1_d = regs_q[rs1_addr];
    rs2_d = regs_q[rs2_addr];
    if (fwd1) begin
      rs1_d = wb_data;
    end
    if (fwd2) begin
      rs2_d = wb_data;
    end
    if (!rs1_nz) begin
      rs1_d = '0;
    end
    if (!rs2_nz) begin
      rs2_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (wb_en && (wb_rd != AW'(RV_X0))) begin
        regs_q[wb_rd] <= wb_data;
      end
      rd_vld_q <= rd_accept;
      if (rd_accept) begin
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
      end
    end
  end

  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;
  assign rd_vld   = rd_vld_q;

endmodule : regfile_read
`default_nettype wire
